perceptron_accumulator: RTL

Computes the weighted sum feeding the single-perceptron activation stage: bias + Σ(x_i·w_i) over N_INPUTS operand pairs. The pairs are streamed in with a valid/ready handshake. Multiplication is pipelined and accumulation is in 48 bits. The block emits a one-cycle-valid signed 48-bit sum that connects directly to the activation function's 48-bit input.

---
 rtl/perceptron_accumulator_if.sv | 26 ++
 rtl/perceptron_accumulator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/perceptron_accumulator_if.sv
// Streaming operand/result bundle for the perceptron weighted-sum accumulator.
// The master side drives operands and start; the slave side returns the sum.
interface perceptron_accumulator_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48
);
    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic signed [ACC_W-1:0]  sum_out;
    logic                     sum_valid;
    logic                     busy;

    modport master (
        output start, bias, in_valid, x_in, w_in,
        input  in_ready, sum_out, sum_valid, busy
    );

    modport slave (
        input  start, bias, in_valid, x_in, w_in,
        output in_ready, sum_out, sum_valid, busy
    );
endinterface

// File: rtl/perceptron_accumulator.sv
// Weighted sum bias + sum(x_i*w_i) over N_INPUTS streamed pairs, with a
// registered multiply stage ahead of a 48-bit wrapping accumulator.
module perceptron_accumulator #(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ACC_W    = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    perceptron_accumulator_if.slave bus
);
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_prod_v;
    logic [COUNT_W-1:0]        r_count;
    logic signed [ACC_W-1:0]   r_sum;
    logic                      r_sum_valid;
    logic                      r_in_ready;
    logic                      r_busy;

    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic signed [PROD_W-1:0]  w_prod_nxt;
    logic                      w_prod_v_nxt;
    logic [COUNT_W-1:0]        w_count_nxt;
    logic signed [ACC_W-1:0]   w_sum_nxt;
    logic                      w_sum_valid_nxt;
    logic                      w_in_ready_nxt;
    logic                      w_busy_nxt;

    logic                      w_beat;
    logic signed [PROD_W-1:0]  w_mult;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_acc_plus;

    assign w_beat     = bus.in_valid && r_in_ready;
    assign w_mult     = $signed(bus.x_in) * $signed(bus.w_in);
    assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_bias_ext = {{(ACC_W - DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
    assign w_acc_plus = r_acc + w_prod_ext;

    // Next-state and next-value logic; the accumulator absorbs a pending product every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_prod_nxt      = r_prod;
        w_prod_v_nxt    = 1'b0;
        w_count_nxt     = r_count;
        w_sum_nxt       = r_sum;
        w_sum_valid_nxt = 1'b0;

        if (r_prod_v) begin
            w_acc_nxt = w_acc_plus;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_ACCUM;
                    w_acc_nxt   = w_bias_ext;
                    w_count_nxt = '0;
                end
            end
            S_ACCUM: begin
                if (w_beat) begin
                    w_prod_nxt   = w_mult;
                    w_prod_v_nxt = 1'b1;
                    w_count_nxt  = r_count + COUNT_W'(1);
                    if (r_count == COUNT_W'(N_INPUTS - 1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final product is still in flight, so fold it into the result directly.
                w_state_nxt     = S_IDLE;
                w_sum_nxt       = w_acc_plus;
                w_sum_valid_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_ACCUM);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_count     <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_prod      <= w_prod_nxt;
            r_prod_v    <= w_prod_v_nxt;
            r_count     <= w_count_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_valid <= w_sum_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.sum_out   = r_sum;
    assign bus.sum_valid = r_sum_valid;
endmodule
